// File: rtl/pipe_pkg.sv
// Shared slice state encoding and occupancy-width helper for the elastic pipeline chain.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } slice_state_t;

  // Counter width sized for the larger (skid) capacity so both builds share one port width.
  function automatic int unsigned cntWidth(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One elastic slice: a 2-entry skid buffer with PIPE_SKID_EN, else a single valid/data register.
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 70
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

`ifdef PIPE_SKID_EN
  slice_state_t     state;
  logic [WIDTH-1:0] skidData;
  logic             inFire;
  logic             outFire;

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  // out_data is the main entry; in_ready and out_valid are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_data  <= '0;
      skidData  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            state     <= ONE;
            out_data  <= in_data;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (inFire && !outFire) begin
            state    <= TWO;
            skidData <= in_data;
            in_ready <= 1'b0;
          end else if (outFire && !inFire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (inFire && outFire) begin
            out_data <= in_data;
          end
        end
        TWO: begin
          if (outFire) begin
            state    <= ONE;
            out_data <= skidData;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
`else
  // Ready ripples combinationally from downstream when this slice is occupied.
  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
`endif

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised elastic register chain of STAGES pipe_slice instances with flush and occupancy.
// Build option: define PIPE_SKID_EN for 2-entry skid slices with registered ready.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter  int unsigned WIDTH  = 70,
  parameter  int unsigned STAGES = 1,
  localparam int unsigned CNT_W  = cntWidth(STAGES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  if (STAGES == 0) begin : gBadStages
    $error("pipe_stage_chain: STAGES must be at least 1");
  end

  // Each stage keeps its own link signals so the ready ripple has no self-referencing vector.
  for (genvar k = 0; k < STAGES; k++) begin : gStage
    logic             upValid;
    logic [WIDTH-1:0] upData;
    logic             sliceInReady;
    logic             sliceOutValid;
    logic             sliceOutReady;
    logic [WIDTH-1:0] sliceOutData;

    if (k == 0) begin : gHead
      assign upValid  = in_valid;
      assign upData   = in_data;
      assign in_ready = sliceInReady;
    end else begin : gLink
      assign upValid = gStage[k-1].sliceOutValid;
      assign upData  = gStage[k-1].sliceOutData;
    end

    if (k == STAGES - 1) begin : gTail
      assign sliceOutReady = out_ready;
      assign out_valid     = sliceOutValid;
      assign out_data      = sliceOutData;
    end else begin : gNext
      assign sliceOutReady = gStage[k+1].sliceInReady;
    end

    pipe_slice #(
      .WIDTH(WIDTH)
    ) uSlice (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (upValid),
      .in_ready (sliceInReady),
      .in_data  (upData),
      .out_valid(sliceOutValid),
      .out_ready(sliceOutReady),
      .out_data (sliceOutData)
    );
  end

  logic inFire;
  logic outFire;

  assign inFire  = in_valid & in_ready;
  assign outFire = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (inFire && !outFire) begin
      occupancy <= occupancy + CNT_W'(1);
    end else if (outFire && !inFire) begin
      occupancy <= occupancy - CNT_W'(1);
    end
  end

endmodule
